hazard_scoreboard: RTL

//  Parametrised scoreboard hazard unit for the 5-stage pipeline (branches resolved in ID).

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_reg_counter.sv | 53 +++++
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared constants and helpers for the scoreboard hazard unit.
//   HZ_ALU_LAT_DEF / HZ_LOAD_LAT_DEF : default producer latencies (stall cycles)
//   REG_ZERO                         : index of the hard-wired zero register
//   hz_sat_dec                       : decrement that stops at zero
//   hz_max                           : larger of two values
// ----------------------------------------------------------------------------
package hazard_pkg;

   localparam int HZ_ALU_LAT_DEF  = 3;
   localparam int HZ_LOAD_LAT_DEF = 3;
   localparam int REG_ZERO        = 0;

   function automatic int hz_sat_dec(input int v);
      return (v == 0) ? 0 : v - 1;
   endfunction

   function automatic int hz_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// ----------------------------------------------------------------------------
// hazard_reg_counter
//   Countdown counter for one architectural register. A non-zero count means
//   a write to the register is still too far back in the pipeline for an
//   ID-stage consumer to pick it up.
//   Ports:
//     clock_i    : clock, rising edge
//     reset_i    : synchronous active-high reset, clears the count
//     load_i     : an issuing instruction writes this register this cycle
//     memRead_i  : that writer is a load (selects LOAD_LAT instead of ALU_LAT)
//     busy_o     : count is non-zero
// ----------------------------------------------------------------------------
module hazard_reg_counter
   import hazard_pkg::*;
#(
   parameter int CNT_W    = 3,
   parameter int ALU_LAT  = HZ_ALU_LAT_DEF,
   parameter int LOAD_LAT = HZ_LOAD_LAT_DEF
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic load_i,
   input  logic memRead_i,
   output logic busy_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   int               decVal;
   int               latVal;

   // A new writer takes the larger of its own latency and what is left of an
   // older write, so a quick ALU write can never hide a slower pending load.
   always_comb begin
      decVal = hz_sat_dec(int'(cnt_q));
      latVal = memRead_i ? LOAD_LAT : ALU_LAT;
      cnt_d  = CNT_W'(decVal);
      if (load_i) begin
         cnt_d = CNT_W'(hz_max(latVal, decVal));
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//   Scoreboard hazard unit for a 5-stage pipeline with branches resolved in ID.
//   Each register has a countdown of cycles until its pending value becomes
//   readable in ID; the instruction in IF/ID is held while any source it
//   reads is still counting down.
//   Ports:
//     Clk, Reset         : clock and synchronous active-high reset
//     IF_ID_*            : decoded fields of the instruction sitting in IF/ID
//     Flush_In           : IF/ID is being flushed this cycle
//     Stall              : hold PC and IF/ID
//     FlushSignal        : insert a bubble into ID/EX (same as Stall)
//     Busy               : per-register pending-write flags (bit 0 always 0)
//     StallCount         : saturating count of stalled cycles since reset
// ----------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int ALU_LAT  = HZ_ALU_LAT_DEF,
   parameter int LOAD_LAT = HZ_LOAD_LAT_DEF,
   parameter int CNT_W    = 3,
   parameter int STAT_W   = 32
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                IF_ID_Valid,
   input  logic [REG_AW-1:0]   IF_ID_Rs,
   input  logic [REG_AW-1:0]   IF_ID_Rt,
   input  logic                IF_ID_UsesRs,
   input  logic                IF_ID_UsesRt,
   input  logic                IF_ID_RegWrite,
   input  logic [REG_AW-1:0]   IF_ID_WriteReg,
   input  logic                IF_ID_MemRead,
   input  logic                Flush_In,
   output logic                Stall,
   output logic                FlushSignal,
   output logic [NUM_REGS-1:0] Busy,
   output logic [STAT_W-1:0]   StallCount
);

   logic              hitRs;
   logic              hitRt;
   logic              issue;
   logic [STAT_W-1:0] statCnt_q;
   logic [STAT_W-1:0] statCnt_d;

   // Valid is tested first so that garbage source fields on a bubble cannot
   // leak into Stall.
   always_comb begin
      hitRs = IF_ID_Valid & IF_ID_UsesRs &
              (IF_ID_Rs != REG_AW'(REG_ZERO)) & Busy[IF_ID_Rs];
      hitRt = IF_ID_Valid & IF_ID_UsesRt &
              (IF_ID_Rt != REG_AW'(REG_ZERO)) & Busy[IF_ID_Rt];
      Stall = IF_ID_Valid & ~Flush_In & ~Reset & (hitRs | hitRt);
      issue = IF_ID_Valid & ~Stall & ~Flush_In & ~Reset;
   end

   assign FlushSignal = Stall;

   // Register 0 is never written, so it never gets a counter.
   assign Busy[0] = 1'b0;

   generate
      for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
         hazard_reg_counter #(
            .CNT_W    (CNT_W),
            .ALU_LAT  (ALU_LAT),
            .LOAD_LAT (LOAD_LAT)
         ) u_cnt (
            .clock_i   (Clk),
            .reset_i   (Reset),
            .load_i    (issue & IF_ID_RegWrite &
                        (IF_ID_WriteReg == REG_AW'(r))),
            .memRead_i (IF_ID_MemRead),
            .busy_o    (Busy[r])
         );
      end
   endgenerate

   // Stall statistics stick at all-ones instead of wrapping.
   always_comb begin
      statCnt_d = statCnt_q;
      if (Stall && (statCnt_q != '1)) begin
         statCnt_d = statCnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         statCnt_q <= '0;
      end else begin
         statCnt_q <= statCnt_d;
      end
   end

   assign StallCount = statCnt_q;

endmodule
